dram_app_burst_tester: RTL and testbench
========================================

# dram_app_burst_tester

Synthesizable traffic master for the MIG 7-series DDR3 user (app) interface in the DDR3 measurement setup. It runs in the `ui_clk` domain directly upstream of `mig_7series_0`. After `init_calib_complete`, a start pulse makes it write a programmable number of 256-bit bursts with a deterministic pattern, read them back in order, and report the pass/fail result, the error count and the index of the first failing burst.

## Interface
- `ADDR_WIDTH`, 29: width of `app_addr`.
- `APP_DATA_WIDTH`, 256: width of app read and write data (8 lanes of 32 bits).
- `APP_MASK_WIDTH`, 32: width of `app_wdf_mask`.
- `CNT_WIDTH`, 16: width of the burst count and the burst indices.
- `ADDR_STRIDE`, 8: address increment per burst (BL8 on a x32 bus).
- `SEED`, 32'hA5A5_0000: pattern seed.
- `TIMEOUT_CYCLES`, 1048576: number of no-progress cycles that trips the watchdog.

Ports (clock and reset first):
- `ui_clk` in 1: the single clock. All logic is rising-edge.
- `ui_clk_sync_rst` in 1: asynchronous, active-high reset.
- `init_calib_complete` in 1: MIG calibration done.
- `start` in 1: single-cycle run request.
- `base_addr` in ADDR_WIDTH: first burst address, latched on start.
- `num_bursts` in CNT_WIDTH: number of bursts, latched on start.
- `app_en`, `app_cmd[2:0]`, `app_addr` out: command channel.
- `app_rdy` in 1: command accepted.
- `app_wdf_wren`, `app_wdf_end`, `app_wdf_data`, `app_wdf_mask` out: write data channel.
- `app_wdf_rdy` in 1: write data accepted.
- `app_rd_data` in APP_DATA_WIDTH, `app_rd_data_valid` in 1: read return. `app_rd_data_end` is not used.
- `busy` out 1: a run is in progress.
- `done` out 1: level, held until the next accepted start.
- `pass` out 1: result, valid while `done` is high.
- `timeout` out 1: the watchdog tripped during the run.
- `err_count` out CNT_WIDTH: mismatching bursts, saturates at all-ones.
- `first_err_idx` out CNT_WIDTH: burst index of the first mismatch.

## Operation
- States: IDLE, WRITE, READ, DRAIN, FINISH.
- IDLE:
  - `start` is accepted only when `init_calib_complete` is high. Otherwise it is ignored and nothing changes.
  - On accept: latch `base_addr` and `num_bursts`; clear `done`, `pass`, `timeout`, `err_count`, `first_err_idx` and all indices; go to WRITE.
  - If `num_bursts == 0`, go straight to FINISH.
- Pattern: lane k (bits 32k+31:32k) of burst i = `(i*8 + k) ^ SEED`, computed in 32-bit arithmetic.
- Address of burst i = `base_addr + i*ADDR_STRIDE`, taken modulo 2^ADDR_WIDTH (wraps silently).
- WRITE:
  - Drive `app_cmd` = 3'b000, `app_wdf_mask` = 0 and `app_wdf_end` = `app_wdf_wren` (one beat per burst, 4:1 mode).
  - For write index wi, `app_en` and `app_wdf_wren` are both asserted. Each one drops independently once accepted (`app_rdy` or `app_wdf_rdy` high).
  - wi advances in the cycle where both channels have been accepted, counting acceptances in earlier cycles. The next burst is presented in the following cycle, with no bubble.
  - After burst `num_bursts-1` completes, go to READ.
- READ:
  - `app_cmd` = 3'b001, `app_en` held high. The read command index ri advances on every cycle with `app_rdy` high.
  - After the last command is accepted, go to DRAIN.
- Read return (runs in READ and DRAIN):
  - Each `app_rd_data_valid` beat is compared against the pattern for the return index qi; qi then increments.
  - The compare result is registered, giving 1 cycle of compare latency.
  - On a mismatch, `err_count` increments (saturating). The first mismatch also captures `first_err_idx` = qi.
  - Valid beats seen in IDLE or FINISH, or after qi reaches `num_bursts`, are ignored.
- DRAIN: go to FINISH once qi == `num_bursts` and the last compare has been registered.
- Watchdog:
  - A counter runs in WRITE, READ and DRAIN and clears on every acceptance or valid beat.
  - When it reaches TIMEOUT_CYCLES: set `timeout`, drop `app_en` and `app_wdf_wren`, go to FINISH.
- FINISH:
  - `done` = 1 and `pass` = (`err_count` == 0 && !`timeout`).
  - Return to IDLE in the next cycle; `done` and `pass` stay held.
- `start` while `busy` is ignored.

## Timing
- Reset values: `app_en`, `app_wdf_wren`, `app_wdf_end`, `busy`, `done`, `pass`, `timeout` = 0. `err_count`, `first_err_idx`, `app_addr`, `app_cmd`, `app_wdf_data`, `app_wdf_mask` = 0. State = IDLE.
- Reset asserted mid-run: all outputs drop to their reset values immediately (asynchronous). Outstanding MIG reads are discarded.
- Start to first `app_en`/`app_wdf_wren`: 1 cycle.
- `app_addr`, `app_cmd` and `app_wdf_data` are stable for as long as their enable is high and not yet accepted.
- Peak throughput is 1 burst/cycle for writes and 1 read command/cycle when the ready signals stay high.
- `busy` is high from the cycle after start through the FINISH cycle. `done` rises in the same cycle that `busy` falls.
- Last valid beat to `done`: 2 cycles.

## Test plan
- Calibration low, then `start` → no `app_en`, `busy` stays 0. After calibration goes high, start with `num_bursts`=4 and `base_addr`=0 → 4 writes at addresses 0/8/16/24, then 4 reads. Ideal memory gives `done`=1, `pass`=1, `err_count`=0.
- `app_wdf_rdy` low for 3 cycles while `app_rdy` is high → command accepted first, data held stable, wi advances only once data is accepted. Same check with the two roles swapped.
- Corrupt lane 3 of return beat 2 → `err_count`=1, `first_err_idx`=2, `pass`=0.
- `num_bursts`=0 → `done`=1 and `pass`=1 within 2 cycles of start, no app traffic.
- `base_addr`=2^29-8, `num_bursts`=2 → addresses 0x1FFFFFF8 then 0x0000000.
- `app_rdy` held low for TIMEOUT_CYCLES → `timeout`=1, `pass`=0. Separately, assert reset mid-READ → all outputs return to their reset values immediately.

Source files
------------

// File: rtl/dram_app_burst_tester.sv
// Traffic master for the MIG 7-series app interface: writes a run of patterned
// bursts, reads them back in order and reports pass/fail, error count and first failing burst.
module dram_app_burst_tester #(
   parameter int          ADDR_WIDTH     = 29,
   parameter int          APP_DATA_WIDTH = 256,
   parameter int          APP_MASK_WIDTH = 32,
   parameter int          CNT_WIDTH      = 16,
   parameter int          ADDR_STRIDE    = 8,
   parameter logic [31:0] SEED           = 32'hA5A5_0000,
   parameter int          TIMEOUT_CYCLES = 1048576
) (
   input  logic                      ui_clk,
   input  logic                      ui_clk_sync_rst,
   input  logic                      init_calib_complete,
   input  logic                      start,
   input  logic [ADDR_WIDTH-1:0]     base_addr,
   input  logic [CNT_WIDTH-1:0]      num_bursts,
   output logic                      app_en,
   output logic [2:0]                app_cmd,
   output logic [ADDR_WIDTH-1:0]     app_addr,
   input  logic                      app_rdy,
   output logic                      app_wdf_wren,
   output logic                      app_wdf_end,
   output logic [APP_DATA_WIDTH-1:0] app_wdf_data,
   output logic [APP_MASK_WIDTH-1:0] app_wdf_mask,
   input  logic                      app_wdf_rdy,
   input  logic [APP_DATA_WIDTH-1:0] app_rd_data,
   input  logic                      app_rd_data_valid,
   output logic                      busy,
   output logic                      done,
   output logic                      pass,
   output logic                      timeout,
   output logic [CNT_WIDTH-1:0]      err_count,
   output logic [CNT_WIDTH-1:0]      first_err_idx
);
   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_WRITE  = 3'd1;
   localparam logic [2:0] S_READ   = 3'd2;
   localparam logic [2:0] S_DRAIN  = 3'd3;
   localparam logic [2:0] S_FINISH = 3'd4;
   localparam logic [2:0] CMD_WR   = 3'b000;
   localparam logic [2:0] CMD_RD   = 3'b001;
   localparam int         WD_W     = $clog2(TIMEOUT_CYCLES + 1);
   localparam int         LANES    = APP_DATA_WIDTH / 32;

   function automatic logic [APP_DATA_WIDTH-1:0] burst_pattern(input logic [CNT_WIDTH-1:0] idx);
      logic [APP_DATA_WIDTH-1:0] pat;
      pat = {APP_DATA_WIDTH{1'b0}};
      for (int k = 0; k < LANES; k++) begin
         pat[32*k +: 32] = ((32'(idx) << 3) + 32'(k)) ^ SEED;
      end
      return pat;
   endfunction

   logic [2:0]                state_r;
   logic [ADDR_WIDTH-1:0]     base_r;
   logic [CNT_WIDTH-1:0]      num_r, wi_r, ri_r, qi_r;
   logic                      cmd_acc_r, dat_acc_r;
   logic                      app_en_r, app_wdf_wren_r;
   logic [2:0]                app_cmd_r;
   logic [ADDR_WIDTH-1:0]     app_addr_r;
   logic [APP_DATA_WIDTH-1:0] app_wdf_data_r;
   logic                      busy_r, done_r, pass_r, timeout_r;
   logic [CNT_WIDTH-1:0]      err_count_r, first_err_idx_r, cmp_idx_r;
   logic                      cmp_valid_r, cmp_err_r;
   logic [WD_W-1:0]           wd_r;

   logic cmd_fire_s, dat_fire_s, cmd_done_s, dat_done_s;
   logic start_acc_s, running_s, progress_s, wd_trip_s, rd_take_s;
   logic [CNT_WIDTH-1:0] wi_next_s, ri_next_s;

   // An acceptance seen in an earlier cycle counts toward completing the current burst.
   assign cmd_fire_s  = app_en_r & app_rdy;
   assign dat_fire_s  = app_wdf_wren_r & app_wdf_rdy;
   assign cmd_done_s  = cmd_acc_r | cmd_fire_s;
   assign dat_done_s  = dat_acc_r | dat_fire_s;
   assign start_acc_s = (state_r == S_IDLE) & start & init_calib_complete;
   assign running_s   = (state_r == S_WRITE) | (state_r == S_READ) | (state_r == S_DRAIN);
   assign progress_s  = cmd_fire_s | dat_fire_s | app_rd_data_valid;
   assign wd_trip_s   = running_s & ~progress_s & (wd_r == WD_W'(TIMEOUT_CYCLES - 1));
   assign wi_next_s   = wi_r + CNT_WIDTH'(1);
   assign ri_next_s   = ri_r + CNT_WIDTH'(1);
   assign rd_take_s   = ((state_r == S_READ) | (state_r == S_DRAIN)) & app_rd_data_valid & (qi_r < num_r);

   assign app_en        = app_en_r;
   assign app_cmd       = app_cmd_r;
   assign app_addr      = app_addr_r;
   assign app_wdf_wren  = app_wdf_wren_r;
   assign app_wdf_end   = app_wdf_wren_r;
   assign app_wdf_data  = app_wdf_data_r;
   assign app_wdf_mask  = {APP_MASK_WIDTH{1'b0}};
   assign busy          = busy_r;
   assign done          = done_r;
   assign pass          = pass_r;
   assign timeout       = timeout_r;
   assign err_count     = err_count_r;
   assign first_err_idx = first_err_idx_r;

   // Run sequencer: command/write-data channels and status flags.
   always_ff @(posedge ui_clk or posedge ui_clk_sync_rst) begin
      if (ui_clk_sync_rst) begin
         state_r        <= S_IDLE;
         base_r         <= {ADDR_WIDTH{1'b0}};
         num_r          <= {CNT_WIDTH{1'b0}};
         wi_r           <= {CNT_WIDTH{1'b0}};
         ri_r           <= {CNT_WIDTH{1'b0}};
         cmd_acc_r      <= 1'b0;
         dat_acc_r      <= 1'b0;
         app_en_r       <= 1'b0;
         app_wdf_wren_r <= 1'b0;
         app_cmd_r      <= 3'b000;
         app_addr_r     <= {ADDR_WIDTH{1'b0}};
         app_wdf_data_r <= {APP_DATA_WIDTH{1'b0}};
         busy_r         <= 1'b0;
         done_r         <= 1'b0;
         pass_r         <= 1'b0;
         timeout_r      <= 1'b0;
      end else begin
         case (state_r)
            S_IDLE: begin
               if (start_acc_s) begin
                  base_r         <= base_addr;
                  num_r          <= num_bursts;
                  wi_r           <= {CNT_WIDTH{1'b0}};
                  ri_r           <= {CNT_WIDTH{1'b0}};
                  cmd_acc_r      <= 1'b0;
                  dat_acc_r      <= 1'b0;
                  app_cmd_r      <= CMD_WR;
                  app_addr_r     <= base_addr;
                  app_wdf_data_r <= burst_pattern({CNT_WIDTH{1'b0}});
                  busy_r         <= 1'b1;
                  done_r         <= 1'b0;
                  pass_r         <= 1'b0;
                  timeout_r      <= 1'b0;
                  if (num_bursts == {CNT_WIDTH{1'b0}}) begin
                     state_r <= S_FINISH;
                  end else begin
                     state_r        <= S_WRITE;
                     app_en_r       <= 1'b1;
                     app_wdf_wren_r <= 1'b1;
                  end
               end
            end
            S_WRITE: begin
               if (wd_trip_s) begin
                  timeout_r      <= 1'b1;
                  app_en_r       <= 1'b0;
                  app_wdf_wren_r <= 1'b0;
                  state_r        <= S_FINISH;
               end else if (cmd_done_s && dat_done_s) begin
                  wi_r      <= wi_next_s;
                  cmd_acc_r <= 1'b0;
                  dat_acc_r <= 1'b0;
                  if (wi_next_s == num_r) begin
                     state_r        <= S_READ;
                     app_en_r       <= 1'b1;
                     app_wdf_wren_r <= 1'b0;
                     app_cmd_r      <= CMD_RD;
                     app_addr_r     <= base_r;
                  end else begin
                     app_en_r       <= 1'b1;
                     app_wdf_wren_r <= 1'b1;
                     app_addr_r     <= app_addr_r + ADDR_WIDTH'(ADDR_STRIDE);
                     app_wdf_data_r <= burst_pattern(wi_next_s);
                  end
               end else begin
                  app_en_r       <= ~cmd_done_s;
                  app_wdf_wren_r <= ~dat_done_s;
                  cmd_acc_r      <= cmd_done_s;
                  dat_acc_r      <= dat_done_s;
               end
            end
            S_READ: begin
               if (wd_trip_s) begin
                  timeout_r <= 1'b1;
                  app_en_r  <= 1'b0;
                  state_r   <= S_FINISH;
               end else if (cmd_fire_s) begin
                  ri_r <= ri_next_s;
                  if (ri_next_s == num_r) begin
                     app_en_r <= 1'b0;
                     state_r  <= S_DRAIN;
                  end else begin
                     app_addr_r <= app_addr_r + ADDR_WIDTH'(ADDR_STRIDE);
                  end
               end
            end
            S_DRAIN: begin
               // qi and the registered compare advance together, so qi == num means the last compare is in.
               if (wd_trip_s) begin
                  timeout_r <= 1'b1;
                  state_r   <= S_FINISH;
               end else if (qi_r == num_r) begin
                  state_r <= S_FINISH;
               end
            end
            S_FINISH: begin
               busy_r  <= 1'b0;
               done_r  <= 1'b1;
               pass_r  <= (err_count_r == {CNT_WIDTH{1'b0}}) & ~timeout_r;
               state_r <= S_IDLE;
            end
            default: begin
               state_r <= S_IDLE;
            end
         endcase
      end
   end

   // Read-return checker: registered compare, then saturating error accounting.
   always_ff @(posedge ui_clk or posedge ui_clk_sync_rst) begin
      if (ui_clk_sync_rst) begin
         qi_r            <= {CNT_WIDTH{1'b0}};
         cmp_valid_r     <= 1'b0;
         cmp_err_r       <= 1'b0;
         cmp_idx_r       <= {CNT_WIDTH{1'b0}};
         err_count_r     <= {CNT_WIDTH{1'b0}};
         first_err_idx_r <= {CNT_WIDTH{1'b0}};
      end else if (start_acc_s) begin
         qi_r            <= {CNT_WIDTH{1'b0}};
         cmp_valid_r     <= 1'b0;
         cmp_err_r       <= 1'b0;
         err_count_r     <= {CNT_WIDTH{1'b0}};
         first_err_idx_r <= {CNT_WIDTH{1'b0}};
      end else begin
         cmp_valid_r <= rd_take_s;
         if (rd_take_s) begin
            cmp_err_r <= (app_rd_data != burst_pattern(qi_r));
            cmp_idx_r <= qi_r;
            qi_r      <= qi_r + CNT_WIDTH'(1);
         end
         if (cmp_valid_r && cmp_err_r) begin
            if (err_count_r != {CNT_WIDTH{1'b1}}) begin
               err_count_r <= err_count_r + CNT_WIDTH'(1);
            end
            if (err_count_r == {CNT_WIDTH{1'b0}}) begin
               first_err_idx_r <= cmp_idx_r;
            end
         end
      end
   end

   // No-progress watchdog for the active states.
   always_ff @(posedge ui_clk or posedge ui_clk_sync_rst) begin
      if (ui_clk_sync_rst) begin
         wd_r <= {WD_W{1'b0}};
      end else if (!running_s || progress_s) begin
         wd_r <= {WD_W{1'b0}};
      end else begin
         wd_r <= wd_r + WD_W'(1);
      end
   end
endmodule

// File: tb/tb_dram_app_burst_tester.sv
// Scoreboard bench for dram_app_burst_tester: a small MIG memory model answers reads,
// expected traffic and run results are queued at start and compared as the DUT produces them.
module tb_dram_app_burst_tester;
   typedef struct {
      logic        pass;
      logic        timeout;
      logic [15:0] err;
      logic [15:0] first;
   } res_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         init_calib_complete = 1'b0;
   logic         start = 1'b0;
   logic [28:0]  base_addr = 29'd0;
   logic [15:0]  num_bursts = 16'd0;
   logic         app_en, app_wdf_wren, app_wdf_end;
   logic [2:0]   app_cmd;
   logic [28:0]  app_addr;
   logic         app_rdy = 1'b1;
   logic         app_wdf_rdy = 1'b1;
   logic [255:0] app_wdf_data;
   logic [31:0]  app_wdf_mask;
   logic [255:0] app_rd_data;
   logic         app_rd_data_valid;
   logic         busy, done, pass, timeout;
   logic [15:0]  err_count, first_err_idx;

   int n_checks = 0;
   int n_fail = 0;
   logic [28:0]  exp_waddr[$];
   logic [28:0]  exp_raddr[$];
   logic [255:0] exp_wdata[$];
   res_t         res_q[$];
   logic [28:0]  wcmd_q[$];
   logic [255:0] wdata_q[$];
   logic [255:0] mem[logic [28:0]];
   logic         flush = 1'b0;
   int corrupt_at = -1;
   int ret_cnt = 0;
   int tick = 0;
   int last_beat_tick = 0;
   int done_tick = 0;

   dram_app_burst_tester #(.TIMEOUT_CYCLES(64)) dut (
      .ui_clk(clk), .ui_clk_sync_rst(rst), .init_calib_complete(init_calib_complete),
      .start(start), .base_addr(base_addr), .num_bursts(num_bursts),
      .app_en(app_en), .app_cmd(app_cmd), .app_addr(app_addr), .app_rdy(app_rdy),
      .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end), .app_wdf_data(app_wdf_data),
      .app_wdf_mask(app_wdf_mask), .app_wdf_rdy(app_wdf_rdy), .app_rd_data(app_rd_data),
      .app_rd_data_valid(app_rd_data_valid), .busy(busy), .done(done), .pass(pass),
      .timeout(timeout), .err_count(err_count), .first_err_idx(first_err_idx)
   );

   always #5 clk = ~clk;

   function automatic logic [255:0] pat(input int i);
      logic [255:0] p;
      for (int k = 0; k < 8; k++) p[32*k +: 32] = (i * 8 + k) ^ 32'hA5A5_0000;
      return p;
   endfunction

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_flags"}, {app_en, app_wdf_wren, app_wdf_end, busy, done, pass, timeout}, 7'd0);
      check({tag, "_counts"}, {err_count, first_err_idx}, 32'd0);
      check({tag, "_cmd_addr"}, {app_cmd, app_addr}, 32'd0);
      check({tag, "_wdata"}, app_wdf_data, 256'd0);
      check({tag, "_mask"}, app_wdf_mask, 32'd0);
   endtask

   // Queue the expected traffic and result, then pulse start; returns at the first cycle after accept.
   task automatic start_run(input logic [28:0] base, input int num, input int corrupt, input logic exp_to);
      res_t r;
      logic [28:0] a;
      for (int i = 0; i < num; i++) begin
         a = base + 29'(i * 8);
         exp_waddr.push_back(a);
         exp_raddr.push_back(a);
         exp_wdata.push_back(pat(i));
      end
      r.timeout = exp_to;
      r.err     = (!exp_to && corrupt >= 0 && corrupt < num) ? 16'd1 : 16'd0;
      r.first   = (r.err != 16'd0) ? 16'(corrupt) : 16'd0;
      r.pass    = !exp_to && (r.err == 16'd0);
      res_q.push_back(r);
      corrupt_at = (corrupt >= 0) ? ret_cnt + corrupt : -1;
      base_addr  = base;
      num_bursts = 16'(num);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input bit full);
      res_t r;
      int n;
      n = 0;
      while (!done && n < 400) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_done"}, done, 1'b1);
      #4;
      r = res_q.pop_front();
      check({tag, "_pass"}, pass, r.pass);
      check({tag, "_timeout"}, timeout, r.timeout);
      check({tag, "_err_count"}, err_count, r.err);
      check({tag, "_first_err"}, first_err_idx, r.first);
      check({tag, "_busy"}, busy, 1'b0);
      if (full) begin
         // Last beat is sampled on the edge after it is driven; done follows two edges later.
         check({tag, "_beat_to_done"}, 32'(done_tick - last_beat_tick), 32'd3);
         check({tag, "_traffic_left"}, 32'(exp_waddr.size() + exp_raddr.size() + exp_wdata.size()), 32'd0);
      end
   endtask

   // MIG model: observes acceptances, scores them, stores writes and returns reads after 3 cycles.
   initial begin
      logic         pv[3];
      logic [255:0] pd[3];
      logic         rnew_v;
      logic [255:0] rnew_d, d;
      app_rd_data_valid = 1'b0;
      app_rd_data = 256'd0;
      for (int i = 0; i < 3; i++) begin pv[i] = 1'b0; pd[i] = 256'd0; end
      forever begin
         @(negedge clk);
         #3;
         tick++;
         if (done && done_tick < last_beat_tick + 1) done_tick = tick;
         if (rst || flush) begin
            for (int i = 0; i < 3; i++) pv[i] = 1'b0;
            app_rd_data_valid = 1'b0;
            wcmd_q.delete();
            wdata_q.delete();
         end else begin
            rnew_v = 1'b0;
            rnew_d = 256'd0;
            if (app_en && app_rdy && app_cmd == 3'b000) begin
               check("wr_cmd_expected", exp_waddr.size() != 0, 1'b1);
               if (exp_waddr.size() != 0) check("wr_addr", app_addr, exp_waddr.pop_front());
               wcmd_q.push_back(app_addr);
            end
            if (app_wdf_wren && app_wdf_rdy) begin
               check("wr_data_expected", exp_wdata.size() != 0, 1'b1);
               if (exp_wdata.size() != 0) check("wr_data", app_wdf_data, exp_wdata.pop_front());
               check("wr_end_mask", {app_wdf_end, app_wdf_mask}, {1'b1, 32'd0});
               wdata_q.push_back(app_wdf_data);
            end
            while (wcmd_q.size() != 0 && wdata_q.size() != 0) mem[wcmd_q.pop_front()] = wdata_q.pop_front();
            if (app_en && app_rdy && app_cmd != 3'b000) begin
               check("rd_cmd_code", app_cmd, 3'b001);
               check("rd_cmd_expected", exp_raddr.size() != 0, 1'b1);
               if (exp_raddr.size() != 0) check("rd_addr", app_addr, exp_raddr.pop_front());
               rnew_v = 1'b1;
               rnew_d = mem.exists(app_addr) ? mem[app_addr] : 256'd0;
            end
            d = pd[0];
            if (pv[0]) begin
               if (ret_cnt == corrupt_at) d[127:96] = ~d[127:96];
               ret_cnt++;
               last_beat_tick = tick;
            end
            app_rd_data_valid = pv[0];
            app_rd_data = d;
            pv[0] = pv[1]; pd[0] = pd[1];
            pv[1] = pv[2]; pd[1] = pd[2];
            pv[2] = rnew_v; pd[2] = rnew_d;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check_reset("reset");

      // Start while calibration is low must be ignored.
      base_addr = 29'd0; num_bursts = 16'd4; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      check("nocal_busy_en", {busy, app_en, app_wdf_wren, done}, 4'd0);

      init_calib_complete = 1'b1;
      start_run(29'd0, 4, -1, 1'b0);
      check("basic_first_en", {app_en, app_wdf_wren, busy}, 3'b111);
      wait_done("basic", 1'b1);

      // Write data held off for 3 cycles while the command is accepted.
      app_rdy = 1'b1; app_wdf_rdy = 1'b0;
      start_run(29'h100, 2, -1, 1'b0);
      check("ws_c1", {app_en, app_wdf_wren}, 2'b11);
      @(negedge clk);
      check("ws_c2", {app_en, app_wdf_wren}, 2'b01);
      check("ws_c2_hold", {app_addr, app_wdf_data}, {29'h100, pat(0)});
      @(negedge clk);
      check("ws_c3", {app_en, app_wdf_wren}, 2'b01);
      @(negedge clk);
      app_wdf_rdy = 1'b1;
      check("ws_c4_hold", {app_en, app_wdf_wren, app_wdf_data}, {2'b01, pat(0)});
      @(negedge clk);
      check("ws_c5_next", {app_en, app_wdf_wren, app_addr}, {2'b11, 29'h108});
      wait_done("wstall", 1'b1);

      // Command held off for 3 cycles while write data is accepted.
      app_rdy = 1'b0; app_wdf_rdy = 1'b1;
      start_run(29'h200, 2, -1, 1'b0);
      check("cs_c1", {app_en, app_wdf_wren}, 2'b11);
      @(negedge clk);
      check("cs_c2", {app_en, app_wdf_wren, app_addr}, {2'b10, 29'h200});
      @(negedge clk);
      check("cs_c3", {app_en, app_wdf_wren, app_addr}, {2'b10, 29'h200});
      @(negedge clk);
      app_rdy = 1'b1;
      check("cs_c4", {app_en, app_wdf_wren}, 2'b10);
      @(negedge clk);
      check("cs_c5_next", {app_en, app_wdf_wren, app_addr, app_wdf_data}, {2'b11, 29'h208, pat(1)});
      wait_done("cstall", 1'b1);

      start_run(29'h400, 4, 2, 1'b0);
      wait_done("corrupt", 1'b1);

      start_run(29'h10, 0, -1, 1'b0);
      check("zero_c1", {busy, done, app_en, app_wdf_wren}, 4'b1000);
      @(negedge clk);
      check("zero_c2", {busy, done, pass}, 3'b011);
      wait_done("zero", 1'b0);

      start_run(29'h1FFF_FFF8, 2, -1, 1'b0);
      wait_done("wrap", 1'b1);

      app_rdy = 1'b0;
      start_run(29'h80, 2, -1, 1'b1);
      wait_done("wdog", 1'b0);
      exp_waddr.delete(); exp_raddr.delete(); exp_wdata.delete();
      app_rdy = 1'b1;

      // Reset in the middle of the read phase.
      start_run(29'h300, 8, -1, 1'b0);
      n = 0;
      while (!(app_en && app_cmd == 3'b001) && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("mid_read_reached", {app_en, app_cmd}, 4'b1001);
      #1 rst = 1'b1;
      #1 check_reset("mid_reset");
      flush = 1'b1;
      exp_waddr.delete(); exp_raddr.delete(); exp_wdata.delete(); res_q.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      flush = 1'b0;
      check_reset("post_reset");

      start_run(29'h40, 3, -1, 1'b0);
      wait_done("recover", 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
